// File: rtl/alarm_time_keeper.sv
// Running time and stored alarm registers, tick prescaler, and a keypad set-mode FSM
// with a key-wait timeout. Outputs feed the alarm comparator / display mux directly.
module alarm_time_keeper #(
  parameter int TIME_W      = 4,
  parameter int MAX_TIME    = 15,
  parameter int TICK_DIV    = 8,
  parameter int KEY_TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [TIME_W-1:0] key_value,
  input  logic              load_time,
  input  logic              load_alarm,
  input  logic              show_alarm_req,
  output logic [TIME_W-1:0] current_time,
  output logic [TIME_W-1:0] alarm_time,
  output logic              show_a,
  output logic              tick,
  output logic              set_busy
);

  localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int TO_W = (KEY_TIMEOUT > 2) ? $clog2(KEY_TIMEOUT) : 1;
  localparam logic [TIME_W-1:0] MAX_T   = TIME_W'(MAX_TIME);
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(KEY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_TIME  = 2'd1,
    SET_ALARM = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [PS_W-1:0]   r_ps;
  logic [TO_W-1:0]   r_to;
  logic [TIME_W-1:0] r_time;
  logic [TIME_W-1:0] r_alarm;
  logic              r_show_a;
  logic              r_tick;
  logic              r_set_busy;

  logic              w_key_ok;
  logic              w_timeout;
  logic              w_ps_run;
  logic              w_wrap;
  logic              w_time_load;
  logic              w_alarm_load;
  logic [TIME_W-1:0] w_time_inc;

  // Out-of-range keys are treated as if no key was pressed.
  assign w_key_ok     = key_valid && (key_value <= MAX_T);
  assign w_timeout    = (r_to == TO_LAST);
  assign w_ps_run     = (r_state != SET_TIME);
  assign w_wrap       = w_ps_run && (r_ps == PS_LAST);
  assign w_time_load  = (r_state == SET_TIME) && w_key_ok;
  assign w_alarm_load = (r_state == SET_ALARM) && w_key_ok;
  assign w_time_inc   = (r_time == MAX_T) ? '0 : r_time + 1'b1;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN: begin
        if (load_time)       w_state_next = SET_TIME;
        else if (load_alarm) w_state_next = SET_ALARM;
      end
      SET_TIME, SET_ALARM: begin
        if (w_key_ok || w_timeout) w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= RUN;
      r_ps       <= '0;
      r_to       <= '0;
      r_time     <= '0;
      r_alarm    <= '0;
      r_show_a   <= 1'b0;
      r_tick     <= 1'b0;
      r_set_busy <= 1'b0;
    end else begin
      r_state <= w_state_next;

      // Held at zero in RUN so every set-state entry starts a fresh wait.
      if (r_state == RUN) r_to <= '0;
      else                r_to <= r_to + 1'b1;

      if (w_time_load)   r_ps <= '0;
      else if (w_wrap)   r_ps <= '0;
      else if (w_ps_run) r_ps <= r_ps + 1'b1;

      if (w_time_load) r_time <= key_value;
      else if (w_wrap) r_time <= w_time_inc;

      if (w_alarm_load) r_alarm <= key_value;

      r_tick     <= w_wrap && !w_time_load;
      r_show_a   <= show_alarm_req || (w_state_next == SET_ALARM);
      r_set_busy <= (w_state_next != RUN);
    end
  end

  assign current_time = r_time;
  assign alarm_time   = r_alarm;
  assign show_a       = r_show_a;
  assign tick         = r_tick;
  assign set_busy     = r_set_busy;

endmodule

// File: tb/tb_alarm_time_keeper.sv
// Directed bench for alarm_time_keeper (TICK_DIV=4, MAX_TIME=9, KEY_TIMEOUT=16):
// a cycle table for set-time / priority / show, plus hand sequences for the rest.
module tb_alarm_time_keeper;

  logic       clock;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_value;
  logic       load_time;
  logic       load_alarm;
  logic       show_alarm_req;
  logic [3:0] current_time;
  logic [3:0] alarm_time;
  logic       show_a;
  logic       tick;
  logic       set_busy;
  logic       sound_alarm;

  int n_cmp = 0;
  int n_err = 0;

  alarm_time_keeper #(
    .TIME_W(4), .MAX_TIME(9), .TICK_DIV(4), .KEY_TIMEOUT(16)
  ) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_value(key_value),
    .load_time(load_time), .load_alarm(load_alarm), .show_alarm_req(show_alarm_req),
    .current_time(current_time), .alarm_time(alarm_time), .show_a(show_a),
    .tick(tick), .set_busy(set_busy)
  );

  // Downstream comparator behaviour: alarm sounds while the two times match.
  assign sound_alarm = (current_time == alarm_time);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       kv;
    logic [3:0] key;
    logic       lt;
    logic       la;
    logic       sar;
    logic [3:0] e_time;
    logic [3:0] e_alarm;
    logic       e_show;
    logic       e_tick;
    logic       e_busy;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic kv, input logic [3:0] key, input logic lt,
                       input logic la, input logic sar);
    key_valid      = kv;
    key_value      = key;
    load_time      = lt;
    load_alarm     = la;
    show_alarm_req = sar;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input int t, input int a, input int s,
                           input int tk, input int b);
    check({tag, ".time"},  int'(current_time), t);
    check({tag, ".alarm"}, int'(alarm_time),   a);
    check({tag, ".show_a"}, int'(show_a),      s);
    check({tag, ".tick"},  int'(tick),         tk);
    check({tag, ".busy"},  int'(set_busy),     b);
  endtask

  initial begin
    // kv key lt la sar | time alarm show tick busy
    tbl[0]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd8, 4'd0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd8, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd8, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 4'd8, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd8, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd8, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd8, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd9, 4'd0, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd9, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd9, 4'd0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check_all("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Free run: tick on every 4th edge, time 1..9 then wraps to 0, 1.
    for (int c = 1; c <= 44; c++) begin
      step();
      check("run.tick", int'(tick), (c % 4 == 0) ? 1 : 0);
      check("run.time", int'(current_time), (c / 4) % 10);
    end
    $display("free run done: time=%0d", current_time);

    // Set time, then load priority and delayed show.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].kv, tbl[i].key, tbl[i].lt, tbl[i].la, tbl[i].sar);
      step();
      $display("vec %0d: time=%0d alarm=%0d show_a=%0d tick=%0d busy=%0d",
               i, current_time, alarm_time, show_a, tick, set_busy);
      check_all($sformatf("vec%0d", i), int'(tbl[i].e_time), int'(tbl[i].e_alarm),
                int'(tbl[i].e_show), int'(tbl[i].e_tick), int'(tbl[i].e_busy));
    end

    // Invalid key and timeout: 16 busy cycles, prescaler frozen at 3.
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    step();
    check("to.enter_busy", int'(set_busy), 1);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
    step();
    check("to.badkey_busy", int'(set_busy), 1);
    check("to.badkey_time", int'(current_time), 9);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      step();
      check("to.wait_busy", int'(set_busy), 1);
      check("to.wait_tick", int'(tick), 0);
    end
    step();
    check("to.exit_busy", int'(set_busy), 0);
    check("to.exit_time", int'(current_time), 9);
    step();
    check("to.wrap_time", int'(current_time), 0);
    check("to.wrap_tick", int'(tick), 1);
    $display("timeout sequence done: time=%0d", current_time);

    // Set alarm while time keeps running; alarm load lands on an increment.
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step();
    check_all("al.enter", 0, 0, 1, 0, 1);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_all("al.wait1", 0, 0, 1, 0, 1);
    step();
    check_all("al.wait2", 0, 0, 1, 0, 1);
    drive(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    step();
    check_all("al.key", 1, 3, 0, 1, 0);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check("al.sound", int'(sound_alarm), (i == 8) ? 1 : 0);
    end
    $display("alarm sequence done: time=%0d alarm=%0d", current_time, alarm_time);

    // Reset while in SET_ALARM with a valid key: key discarded, all cleared.
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step();
    check("rm.enter_busy", int'(set_busy), 1);
    reset = 1'b1;
    drive(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    step();
    check_all("rm.reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("rm.tick", int'(tick), (i == 4) ? 1 : 0);
      check("rm.time", int'(current_time), (i == 4) ? 1 : 0);
      check("rm.busy", int'(set_busy), 0);
    end
    $display("reset-mid-set sequence done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
